// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, FSM states and datapath mux encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;
   localparam logic [5:0] OP_RFORMAT = 6'd0;
   localparam logic [5:0] OP_JAL     = 6'd3;
   localparam logic [5:0] OP_BEQ     = 6'd4;
   localparam logic [5:0] OP_BNE     = 6'd5;
   localparam logic [5:0] OP_ADDI    = 6'd8;
   localparam logic [5:0] OP_ANDI    = 6'd12;
   localparam logic [5:0] OP_LW      = 6'd35;
   localparam logic [5:0] OP_SW      = 6'd43;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_I_EXEC   = 4'd9,
      S_I_WB     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JAL      = 4'd12,
      S_ERROR    = 4'd13
   } state_e;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags the last allowed one
// Ports: clk, rst_n (async active-low); clear_i zeroes the count; count_i adds one wait cycle;
//        expired_o is high when the current wait cycle is the MEM_TIMEOUT-th (never if MEM_TIMEOUT=0).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);
   localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
   logic [W-1:0] cnt_q, cnt_d;
   // saturate instead of wrapping so a disabled timeout never aliases back to zero
   always_comb cnt_d = clear_i ? '0 : (count_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign expired_o = (MEM_TIMEOUT != 0) && count_i && cnt_q == LAST;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style multi-cycle MIPS control FSM with memory wait/timeout handling
// Ports: clk, rst_n (async active-low); opcode_i = IR[31:26]; mem_ready_i = memory access completes;
//        outputs drive PC/IR/regfile/ALU/memory enables and mux selects of the shared datapath,
//        plus illegal_op_o (1-cycle pulse), bus_error_o (sticky) and state_dbg_o (state encoding).
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int SUPPORT_BNE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       branch_ne_o,
   output logic [1:0] pc_source_o,
   output logic       iord_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic       illegal_op_o,
   output logic       bus_error_o,
   output logic [3:0] state_dbg_o
);
   state_e state_q, state_d;
   logic   waiting, expired;

   // only the three memory-handshake states accumulate wait cycles
   assign waiting = (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready_i;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (state_d != state_q),
      .count_i  (waiting),
      .expired_o(expired)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d         = state_q;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      branch_ne_o     = 1'b0;
      pc_source_o     = PCS_ALU;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_dst_o       = DST_RT;
      mem_to_reg_o    = M2R_ALUOUT;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = SRCB_B;
      alu_op_o        = ALU_ADD;
      illegal_op_o    = 1'b0;
      bus_error_o     = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_4;
            // IR and PC+4 load in the completing cycle itself
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
            state_d     = mem_ready_i ? S_DECODE : expired ? S_ERROR : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b_o = SRCB_IMM4;
            case (opcode_i)
               OP_RFORMAT:      state_d = S_R_EXEC;
               OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
               OP_LW, OP_SW:    state_d = S_MEM_ADDR;
               OP_BEQ:          state_d = S_BRANCH;
               OP_JAL:          state_d = S_JAL;
               OP_BNE: begin
                  state_d      = SUPPORT_BNE != 0 ? S_BRANCH : S_FETCH;
                  illegal_op_o = SUPPORT_BNE == 0;
               end
               default: begin
                  state_d      = S_FETCH;
                  illegal_op_o = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            state_d     = opcode_i == OP_LW ? S_MEM_RD : opcode_i == OP_SW ? S_MEM_WR : S_FETCH;
         end
         S_MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
            state_d    = mem_ready_i ? S_MEM_WB : expired ? S_ERROR : S_MEM_RD;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = M2R_MDR;
            state_d      = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
            state_d     = mem_ready_i ? S_FETCH : expired ? S_ERROR : S_MEM_WR;
         end
         S_R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_FUNCT;
            state_d     = S_R_WB;
         end
         S_R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = DST_RD;
            state_d     = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = opcode_i == OP_ANDI ? ALU_AND : ALU_ADD;
            state_d     = S_I_WB;
         end
         S_I_WB: begin
            reg_write_o = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = ALU_SUB;
            pc_write_cond_o = 1'b1;
            pc_source_o     = PCS_ALUOUT;
            branch_ne_o     = opcode_i == OP_BNE;
            state_d         = S_FETCH;
         end
         S_JAL: begin
            // PC already holds PC+4 from FETCH, so it is the link value
            reg_write_o  = 1'b1;
            reg_dst_o    = DST_RA;
            mem_to_reg_o = M2R_PC;
            pc_write_o   = 1'b1;
            pc_source_o  = PCS_JUMP;
            state_d      = S_FETCH;
         end
         S_ERROR: bus_error_o = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   assign state_dbg_o = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;

   logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
   logic       reg_write, alu_src_a, illegal_op, bus_error;
   logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b, alu_op;
   logic [3:0] state_dbg;

   logic       n_pc_write, n_pc_write_cond, n_branch_ne, n_iord, n_mem_read, n_mem_write, n_ir_write;
   logic       n_reg_write, n_alu_src_a, n_illegal_op, n_bus_error;
   logic [1:0] n_pc_source, n_reg_dst, n_mem_to_reg, n_alu_src_b, n_alu_op;
   logic [3:0] n_state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(16), .SUPPORT_BNE(1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
      .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
      .pc_source_o(pc_source), .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
      .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
      .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .alu_op_o(alu_op), .illegal_op_o(illegal_op), .bus_error_o(bus_error),
      .state_dbg_o(state_dbg)
   );

   multicycle_control #(.MEM_TIMEOUT(16), .SUPPORT_BNE(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
      .pc_write_o(n_pc_write), .pc_write_cond_o(n_pc_write_cond), .branch_ne_o(n_branch_ne),
      .pc_source_o(n_pc_source), .iord_o(n_iord), .mem_read_o(n_mem_read), .mem_write_o(n_mem_write),
      .ir_write_o(n_ir_write), .reg_dst_o(n_reg_dst), .mem_to_reg_o(n_mem_to_reg),
      .reg_write_o(n_reg_write), .alu_src_a_o(n_alu_src_a), .alu_src_b_o(n_alu_src_b),
      .alu_op_o(n_alu_op), .illegal_op_o(n_illegal_op), .bus_error_o(n_bus_error),
      .state_dbg_o(n_state_dbg)
   );

   // {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write, ir_write,
   //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, bus_error}
   logic [20:0] outs;
   assign outs = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, bus_error};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
      tick; tick;
      checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
      checks++; if (outs !== 21'd0) begin errors++; $display("FAIL reset_outs: got %h exp 0", outs); end
   endtask

   task automatic test_rformat;
      rst_n = 1'b1; #1;
      checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL r_idle: got %0d exp 0", state_dbg); end
      checks++; if (outs !== 21'd0) begin errors++; $display("FAIL r_idle_outs: got %h exp 0", outs); end
      tick;
      checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL r_fetch: got %0d exp 1", state_dbg); end
      checks++; if (outs !== 21'b1_0_0_00_0_1_0_1_00_00_0_0_01_00_0_0) begin errors++; $display("FAIL r_fetch_outs: got %h exp %h", outs, 21'b1_0_0_00_0_1_0_1_00_00_0_0_01_00_0_0); end
      tick;
      checks++; if (state_dbg !== 4'd2 || alu_src_b !== 2'b11 || alu_src_a !== 1'b0) begin errors++; $display("FAIL r_decode: got st=%0d srcb=%0d exp st=2 srcb=3", state_dbg, alu_src_b); end
      tick;
      checks++; if (state_dbg !== 4'd7 || alu_op !== 2'b10 || alu_src_a !== 1'b1) begin errors++; $display("FAIL r_exec: got st=%0d op=%0d exp st=7 op=2", state_dbg, alu_op); end
      tick;
      checks++; if (state_dbg !== 4'd8 || outs !== 21'b0_0_0_00_0_0_0_0_01_00_1_0_00_00_0_0) begin errors++; $display("FAIL r_wb: got st=%0d outs=%h exp st=8 outs=%h", state_dbg, outs, 21'b0_0_0_00_0_0_0_0_01_00_1_0_00_00_0_0); end
      tick;
      checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL r_latency: got %0d exp 1 after 4 cycles", state_dbg); end
   endtask

   task automatic test_lw_wait;
      opcode = 6'd35;
      tick;
      tick;
      checks++; if (state_dbg !== 4'd3 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin errors++; $display("FAIL lw_addr: got st=%0d a=%0d b=%0d exp 3/1/2", state_dbg, alu_src_a, alu_src_b); end
      mem_ready = 1'b0;
      tick;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         checks++; if (state_dbg !== 4'd4 || {mem_read, iord} !== 2'b11) begin errors++; $display("FAIL lw_rd_wait%0d: got st=%0d rd/iord=%b exp 4/11", i, state_dbg, {mem_read, iord}); end
         tick;
      end
      checks++; if (state_dbg !== 4'd5 || outs !== 21'b0_0_0_00_0_0_0_0_00_01_1_0_00_00_0_0) begin errors++; $display("FAIL lw_wb: got st=%0d outs=%h exp st=5 outs=%h", state_dbg, outs, 21'b0_0_0_00_0_0_0_0_00_01_1_0_00_00_0_0); end
      tick;
      checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL lw_back_fetch: got %0d exp 1", state_dbg); end
   endtask

   task automatic test_branch;
      opcode = 6'd5;
      tick;
      checks++; if (state_dbg !== 4'd2 || illegal_op !== 1'b0) begin errors++; $display("FAIL bne_decode: got st=%0d ill=%0d exp 2/0", state_dbg, illegal_op); end
      checks++; if (n_state_dbg !== 4'd2 || n_illegal_op !== 1'b1) begin errors++; $display("FAIL nobne_illegal: got st=%0d ill=%0d exp 2/1", n_state_dbg, n_illegal_op); end
      tick;
      checks++; if (state_dbg !== 4'd11 || outs !== 21'b0_1_1_01_0_0_0_0_00_00_0_1_00_01_0_0) begin errors++; $display("FAIL bne_branch: got st=%0d outs=%h exp st=11 outs=%h", state_dbg, outs, 21'b0_1_1_01_0_0_0_0_00_00_0_1_00_01_0_0); end
      checks++; if (n_state_dbg !== 4'd1 || n_illegal_op !== 1'b0) begin errors++; $display("FAIL nobne_fetch: got st=%0d ill=%0d exp 1/0", n_state_dbg, n_illegal_op); end
      tick;
      opcode = 6'd4;
      tick;
      tick;
      checks++; if (state_dbg !== 4'd11 || branch_ne !== 1'b0 || pc_write_cond !== 1'b1) begin errors++; $display("FAIL beq_branch: got st=%0d ne=%0d cond=%0d exp 11/0/1", state_dbg, branch_ne, pc_write_cond); end
      tick;
   endtask

   task automatic test_jal;
      opcode = 6'd3;
      tick;
      tick;
      checks++; if (state_dbg !== 4'd12 || outs !== 21'b1_0_0_10_0_0_0_0_10_10_1_0_00_00_0_0) begin errors++; $display("FAIL jal: got st=%0d outs=%h exp st=12 outs=%h", state_dbg, outs, 21'b1_0_0_10_0_0_0_0_10_10_1_0_00_00_0_0); end
      tick;
      checks++; if (state_dbg !== 4'd1 || {reg_dst, mem_to_reg, pc_source, reg_write} !== 7'd0) begin errors++; $display("FAIL jal_one_cycle: got st=%0d dst=%0d m2r=%0d pcs=%0d rw=%0d exp 1/0/0/0/0", state_dbg, reg_dst, mem_to_reg, pc_source, reg_write); end
   endtask

   task automatic test_illegal;
      opcode = 6'd63;
      tick;
      checks++; if (state_dbg !== 4'd2 || illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got st=%0d ill=%0d exp 2/1", state_dbg, illegal_op); end
      mem_ready = 1'b0;
      tick;
      checks++; if (state_dbg !== 4'd1 || illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_fetch: got st=%0d ill=%0d exp 1/0", state_dbg, illegal_op); end
   endtask

   task automatic test_timeout_ok;
      for (int i = 0; i < 16; i++) begin
         mem_ready = (i == 15);
         #1;
         checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL tmo_ok_wait%0d: got %0d exp 1", i, state_dbg); end
         tick;
      end
      checks++; if (state_dbg !== 4'd2 || bus_error !== 1'b0) begin errors++; $display("FAIL tmo_ok_decode: got st=%0d be=%0d exp 2/0", state_dbg, bus_error); end
      opcode = 6'd0;
      tick;
      tick;
      mem_ready = 1'b0;
      tick;
   endtask

   task automatic test_timeout_err;
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL tmo_wait%0d: got %0d exp 1", i, state_dbg); end
         tick;
      end
      checks++; if (state_dbg !== 4'd13 || outs !== 21'd1) begin errors++; $display("FAIL tmo_error: got st=%0d outs=%h exp 13/1", state_dbg, outs); end
      mem_ready = 1'b1;
      tick; tick; tick;
      checks++; if (state_dbg !== 4'd13 || outs !== 21'd1) begin errors++; $display("FAIL tmo_sticky: got st=%0d outs=%h exp 13/1", state_dbg, outs); end
   endtask

   task automatic test_reset_mid_memwr;
      rst_n = 1'b0;
      tick;
      checks++; if (state_dbg !== 4'd0 || outs !== 21'd0) begin errors++; $display("FAIL err_reset: got st=%0d outs=%h exp 0/0", state_dbg, outs); end
      rst_n = 1'b1; opcode = 6'd43; mem_ready = 1'b1;
      tick; tick; tick;
      mem_ready = 1'b0;
      tick;
      checks++; if (state_dbg !== 4'd6 || outs !== 21'b0_0_0_00_1_0_1_0_00_00_0_0_00_00_0_0) begin errors++; $display("FAIL sw_wr: got st=%0d outs=%h exp st=6 outs=%h", state_dbg, outs, 21'b0_0_0_00_1_0_1_0_00_00_0_0_00_00_0_0); end
      tick;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (state_dbg !== 4'd0 || outs !== 21'd0) begin errors++; $display("FAIL async_reset: got st=%0d outs=%h exp 0/0", state_dbg, outs); end
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL post_reset_idle: got %0d exp 0", state_dbg); end
      tick;
      checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL post_reset_fetch: got %0d exp 1", state_dbg); end
   endtask

   initial begin
      test_reset;
      test_rformat;
      test_lw_wait;
      test_branch;
      test_jal;
      test_illegal;
      test_timeout_ok;
      test_timeout_err;
      test_reset_mid_memwr;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore-style FSM that sequences each MIPS instruction over 3–5 cycles.
- Drives the shared-datapath enables: PC, IR, register file, ALU muxes, memory.
- Adds variable-latency memory support (mem_ready handshake with wait-state timeout), optional BNE, illegal-opcode reporting and a sticky bus-error state.
- Sits between the instruction register's opcode field and the multi-cycle datapath.

Parameters:
- MEM_TIMEOUT, 16: max consecutive wait cycles in any memory state before bus error; 0 disables the timeout.
- SUPPORT_BNE, 1: 1 decodes opcode 5 (BNE); 0 treats it as illegal.

Ports:
- clk, input, 1: clock, all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- opcode, input, 6: IR[31:26]; valid from DECODE onward.
- mem_ready, input, 1: memory completes the current read/write this cycle.
- pc_write, output, 1: unconditional PC load.
- pc_write_cond, output, 1: PC load qualified by ALU zero (inverted when branch_ne=1).
- branch_ne, output, 1: selects not-equal branch sense.
- pc_source, output, 2: 00 ALU result, 01 ALUOut, 10 jump target.
- iord, output, 1: memory address select; 0 PC, 1 ALUOut.
- mem_read, output, 1: memory read request.
- mem_write, output, 1: memory write request.
- ir_write, output, 1: IR load.
- reg_dst, output, 2: 00 rt, 01 rd, 10 $31.
- mem_to_reg, output, 2: 00 ALUOut, 01 MDR, 10 PC.
- reg_write, output, 1: register file write.
- alu_src_a, output, 1: 0 PC, 1 A.
- alu_src_b, output, 2: 00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op, output, 2: 00 add, 01 sub, 10 funct field, 11 and.
- illegal_op, output, 1: one-cycle pulse on an undecodable opcode.
- bus_error, output, 1: sticky memory-timeout flag.
- state_dbg, output, 4: current state encoding.

Behaviour:
- Reset: state=IDLE; wait counter=0; all outputs 0; state_dbg=IDLE encoding. Reset asserted mid-instruction aborts it immediately with no pending enables.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0 → FETCH the next cycle.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - If mem_ready=1: also ir_write=1 and pc_write=1 (Mealy, same cycle), → DECODE.
  - Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Next state by opcode:
  - 0 → R_EXEC
  - 8 or 12 → I_EXEC
  - 35 or 43 → MEM_ADDR
  - 4 → BRANCH
  - 5 → BRANCH if SUPPORT_BNE, otherwise illegal
  - 3 → JAL
  - Any other opcode: illegal_op=1 for this cycle, → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD if opcode 35, MEM_WR if 43.
- MEM_RD: mem_read=1, iord=1 → MEM_WB when mem_ready=1.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 → FETCH.
- MEM_WR: mem_write=1, iord=1 → FETCH when mem_ready=1.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op=00 for opcode 8, 11 for opcode 12 → I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==5) → FETCH.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already PC+4), pc_write=1, pc_source=10 → FETCH.
- Latency in cycles, zero-wait memory: R/ADDI/ANDI 4, LW 5, SW 4, BEQ/BNE 3, JAL 3.
- Wait counter (FETCH, MEM_RD, MEM_WR only):
  - Cleared on entry to each of these states.
  - Increments each cycle with mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 with mem_ready=0: → ERROR next cycle.
  - mem_ready=1 in that same cycle wins (normal completion).
  - Counter width clog2(MEM_TIMEOUT+1); saturates, never wraps.
- ERROR: all enables 0, bus_error=1; leaves only via reset.

Decomposition:
- Package mips_ctrl_pkg:
  - opcode constants: RFORMAT=0, ADDI=8, ANDI=12, LW=35, SW=43, BEQ=4, BNE=5, JAL=3
  - state enum, 4-bit
  - ALUOp, ALUSrcB, PCSource, RegDst and MemtoReg encodings
- Sub-module mem_wait_timer (clear, count-enable, expired), parametrised by MEM_TIMEOUT.

Test Plan:
- Reset release, mem_ready held 1, opcode 0 → states IDLE, FETCH, DECODE, R_EXEC, R_WB; R_WB has reg_write=1, reg_dst=01; 4 cycles from FETCH entry to next FETCH.
- LW (35) with mem_ready low 3 cycles in MEM_RD → mem_read=1, iord=1 held 4 cycles; MEM_WB asserts mem_to_reg=01, reg_write=1.
- BNE (5) with SUPPORT_BNE=1 → BRANCH asserts branch_ne=1, pc_write_cond=1, alu_op=01. With SUPPORT_BNE=0 → illegal_op pulses 1 cycle in DECODE, next state FETCH.
- JAL (3) → JAL state asserts reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10 simultaneously for exactly 1 cycle.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH → ERROR after 16 cycles, bus_error=1 sticky. mem_ready=1 in the 16th cycle instead → DECODE, no error.
- rst_n low mid-MEM_WR → all outputs 0 asynchronously; after release, IDLE then FETCH.
